alu_pipe: RTL and testbench

//  Parametrised, pipelined successor to the single-stage execute ALU. Accepts one operation per cycle

---
 rtl/alu_pipe_pkg.sv | 19 +
 rtl/alu_pipe_core.sv | 45 ++++
 rtl/alu_pipe.sv | 96 +++++++++
 tb/tb_alu_pipe.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pipe_pkg.sv
// Shared ALU definitions for the execute lanes.
// The operation encoding is 5 bits wide; unused codes are reported as illegal by alu_core.
package cpu_defs;

   typedef enum logic [4:0] {
      OpAdd  = 5'd0,
      OpSub  = 5'd1,
      OpAnd  = 5'd2,
      OpOr   = 5'd3,
      OpXor  = 5'd4,
      OpSll  = 5'd5,
      OpSrl  = 5'd6,
      OpSra  = 5'd7,
      OpSlt  = 5'd8,
      OpSltu = 5'd9,
      OpMul  = 5'd10
   } alu_op_t;

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational ALU datapath: op/a/b -> result plus an illegal-encoding flag.
// Build option ALU_MUL_EN adds OpMul (low XLEN bits of a*b); without it OpMul is illegal.
module alu_core
   import cpu_defs::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  alu_op_t           i_op,
   input  logic [XLEN-1:0]   i_a,
   input  logic [XLEN-1:0]   i_b,
   output logic [XLEN-1:0]   o_result,
   output logic              o_illegal
);

   localparam int unsigned ShW = $clog2(XLEN);

   // Only the low log2(XLEN) bits of b form the shift amount.
   logic [ShW-1:0] w_shamt;
   assign w_shamt = i_b[ShW-1:0];

   always_comb begin
      o_result  = '0;
      o_illegal = 1'b0;
      case (i_op)
         OpAdd:  o_result = i_a + i_b;
         OpSub:  o_result = i_a - i_b;
         OpAnd:  o_result = i_a & i_b;
         OpOr:   o_result = i_a | i_b;
         OpXor:  o_result = i_a ^ i_b;
         OpSll:  o_result = i_a << w_shamt;
         OpSrl:  o_result = i_a >> w_shamt;
         OpSra:  o_result = $unsigned($signed(i_a) >>> w_shamt);
         OpSlt:  o_result = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
         OpSltu: o_result = {{(XLEN-1){1'b0}}, (i_a < i_b)};
`ifdef ALU_MUL_EN
         OpMul:  o_result = i_a * i_b;
`endif
         default: begin
            o_result  = '0;
            o_illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined execute ALU: compute registered in stage 0, STAGES-1 delay stages, valid/ready both ends.
// Build option ALU_MUL_EN enables OpMul and then requires STAGES >= 2.
module alu_pipe
   import cpu_defs::*;
#(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned STAGES = 2,
   parameter int unsigned TAG_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  alu_op_t           in_op,
   input  logic [XLEN-1:0]   in_a,
   input  logic [XLEN-1:0]   in_b,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_result,
   output logic [TAG_W-1:0]  out_tag,
   output logic              out_zero,
   output logic              out_illegal
);

   typedef struct packed {
      logic              valid;
      logic [XLEN-1:0]   result;
      logic [TAG_W-1:0]  tag;
      logic              zero;
      logic              illegal;
   } alu_stage_t;

   if (STAGES < 1) begin : g_stages_check
      $error("alu_pipe: STAGES must be >= 1");
   end
   if (XLEN < 8) begin : g_xlen_check
      $error("alu_pipe: XLEN must be >= 8");
   end
`ifdef ALU_MUL_EN
   if (STAGES < 2) begin : g_mul_stages_check
      $error("alu_pipe: ALU_MUL_EN requires STAGES >= 2");
   end
`endif

   alu_stage_t        r_pipe [STAGES];
   alu_stage_t        w_stage0;
   logic [XLEN-1:0]   w_result;
   logic              w_illegal;
   logic              w_advance;

   alu_core #(
      .XLEN (XLEN)
   ) u_core (
      .i_op      (in_op),
      .i_a       (in_a),
      .i_b       (in_b),
      .o_result  (w_result),
      .o_illegal (w_illegal)
   );

   // Bubbles carry all-zero payload so idle stages never hold stale data.
   always_comb begin
      w_stage0 = '0;
      if (in_valid) begin
         w_stage0.valid   = 1'b1;
         w_stage0.result  = w_result;
         w_stage0.tag     = in_tag;
         w_stage0.zero    = (w_result == '0);
         w_stage0.illegal = w_illegal;
      end
   end

   assign w_advance = !r_pipe[STAGES-1].valid || out_ready;
   assign in_ready  = w_advance && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(STAGES); i++) begin
            r_pipe[i] <= '0;
         end
      end else if (w_advance) begin
         r_pipe[0] <= w_stage0;
         for (int i = 1; i < int'(STAGES); i++) begin
            r_pipe[i] <= r_pipe[i-1];
         end
      end
   end

   assign out_valid   = r_pipe[STAGES-1].valid;
   assign out_result  = r_pipe[STAGES-1].result;
   assign out_tag     = r_pipe[STAGES-1].tag;
   assign out_zero    = r_pipe[STAGES-1].zero;
   assign out_illegal = r_pipe[STAGES-1].illegal;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (XLEN=32, STAGES=2, TAG_W=8).
// Inputs change on the falling edge; outputs are sampled on the falling edge (or #1 after it).
module tb_alu_pipe;
   import cpu_defs::*;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   alu_op_t       in_op;
   logic [31:0]   in_a;
   logic [31:0]   in_b;
   logic [7:0]    in_tag;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_result;
   logic [7:0]    out_tag;
   logic          out_zero;
   logic          out_illegal;

   int n_vec;
   int n_fail;

   alu_pipe #(
      .XLEN   (32),
      .STAGES (2),
      .TAG_W  (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_op       (in_op),
      .in_a        (in_a),
      .in_b        (in_b),
      .in_tag      (in_tag),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_tag     (out_tag),
      .out_zero    (out_zero),
      .out_illegal (out_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      in_op = OpAdd; in_a = '0; in_b = '0; in_tag = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      n_vec++; if (out_result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", out_result); end
      n_vec++; if (out_tag !== 8'h0) begin n_fail++; $display("FAIL reset_tag: got %h want 0", out_tag); end
      n_vec++; if (out_zero !== 1'b0) begin n_fail++; $display("FAIL reset_zero: got %b want 0", out_zero); end
      n_vec++; if (out_illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b want 0", out_illegal); end
      n_vec++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      rst = 1'b0;
      #1;
      n_vec++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_add_wrap();
      @(negedge clk);
      in_valid = 1'b1; in_op = OpAdd; in_a = 32'hFFFF_FFFF; in_b = 32'h1; in_tag = 8'd5;
      @(negedge clk);
      in_valid = 1'b0;
      n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_latency_early: got %b want 0", out_valid); end
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %b want 1", out_valid); end
      n_vec++; if (out_result !== 32'h0) begin n_fail++; $display("FAIL add_result: got %h want 0", out_result); end
      n_vec++; if (out_zero !== 1'b1) begin n_fail++; $display("FAIL add_zero: got %b want 1", out_zero); end
      n_vec++; if (out_tag !== 8'd5) begin n_fail++; $display("FAIL add_tag: got %h want 05", out_tag); end
      n_vec++; if (out_illegal !== 1'b0) begin n_fail++; $display("FAIL add_illegal: got %b want 0", out_illegal); end
   endtask

   task automatic test_ops();
      alu_op_t     v_op  [9];
      logic [31:0] v_a   [9];
      logic [31:0] v_b   [9];
      logic [31:0] v_exp [9];
      v_op  = '{OpSra, OpSlt, OpSltu, OpSub, OpAnd, OpOr, OpXor, OpSll, OpSrl};
      v_a   = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'h0000_F0F0,
                32'h0000_F0F0, 32'h0000_00FF, 32'h1, 32'h8000_0000};
      v_b   = '{32'h21, 32'h1, 32'h1, 32'd7, 32'h0000_FF00,
                32'h0000_FF00, 32'h0000_000F, 32'h24, 32'd31};
      v_exp = '{32'hC000_0000, 32'h1, 32'h0, 32'hFFFF_FFFE, 32'h0000_F000,
                32'h0000_FFF0, 32'h0000_00F0, 32'h10, 32'h1};
      // Streamed one per cycle: vector t emerges two cycles after it is driven.
      for (int t = 0; t < 11; t++) begin
         @(negedge clk);
         if (t >= 2) begin
            n_vec++;
            if (out_valid !== 1'b1 || out_result !== v_exp[t-2] || out_tag !== 8'(8'h40 + t - 2)
                || out_zero !== (v_exp[t-2] == 32'h0) || out_illegal !== 1'b0) begin
               n_fail++;
               $display("FAIL ops_vec%0d: got v=%b r=%h tag=%h z=%b il=%b want v=1 r=%h tag=%h",
                        t - 2, out_valid, out_result, out_tag, out_zero, out_illegal,
                        v_exp[t-2], 8'(8'h40 + t - 2));
            end
         end
         if (t < 9) begin
            in_valid = 1'b1; in_op = v_op[t]; in_a = v_a[t]; in_b = v_b[t]; in_tag = 8'(8'h40 + t);
         end else begin
            in_valid = 1'b0;
         end
      end
   endtask

   task automatic test_back_to_back();
      int          sent;
      int          got;
      logic        held;
      logic [31:0] held_res;
      logic [7:0]  held_tag;
      logic        exp_rdy;
      sent = 0; got = 0; held = 1'b0; held_res = '0; held_tag = '0;
      for (int c = 0; c < 40 && got < 8; c++) begin
         @(negedge clk);
         out_ready = !(c >= 3 && c <= 6);
         if (sent < 8) begin
            in_valid = 1'b1; in_op = OpAdd; in_a = 32'(sent * 3); in_b = 32'd100;
            in_tag = 8'(sent + 16);
         end else begin
            in_valid = 1'b0;
         end
         #1;
         exp_rdy = !(c >= 3 && c <= 6);
         n_vec++;
         if (in_ready !== exp_rdy) begin
            n_fail++; $display("FAIL b2b_in_ready_c%0d: got %b want %b", c, in_ready, exp_rdy);
         end
         if (held) begin
            n_vec++;
            if (out_valid !== 1'b1 || out_result !== held_res || out_tag !== held_tag) begin
               n_fail++;
               $display("FAIL b2b_stall_hold_c%0d: got v=%b r=%h tag=%h want v=1 r=%h tag=%h",
                        c, out_valid, out_result, out_tag, held_res, held_tag);
            end
         end
         held = 1'b0;
         if (out_valid === 1'b1) begin
            if (out_ready) begin
               n_vec++;
               if (out_tag !== 8'(got + 16) || out_result !== 32'(got * 3 + 100)) begin
                  n_fail++;
                  $display("FAIL b2b_out%0d: got r=%h tag=%h want r=%h tag=%h", got, out_result,
                           out_tag, 32'(got * 3 + 100), 8'(got + 16));
               end
               got++;
            end else begin
               held = 1'b1; held_res = out_result; held_tag = out_tag;
            end
         end
         if (in_valid && in_ready) sent++;
      end
      n_vec++;
      if (got != 8) begin n_fail++; $display("FAIL b2b_count: got %0d results want 8", got); end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (2) begin
         @(negedge clk);
         n_vec++;
         if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_no_dup: got out_valid=%b tag=%h want 0", out_valid, out_tag);
         end
      end
   endtask

   task automatic test_illegal();
      logic [4:0] raw;
      raw = 5'h1F;
      @(negedge clk);
      in_valid = 1'b1; in_op = alu_op_t'(raw); in_a = 32'd5; in_b = 32'd3; in_tag = 8'hAA;
      @(negedge clk);
      in_op = OpAdd; in_a = 32'd2; in_b = 32'd3; in_tag = 8'h01;
      @(negedge clk);
      in_valid = 1'b0;
      n_vec++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL illegal_valid: got %b want 1", out_valid); end
      n_vec++; if (out_illegal !== 1'b1) begin n_fail++; $display("FAIL illegal_flag: got %b want 1", out_illegal); end
      n_vec++; if (out_result !== 32'h0) begin n_fail++; $display("FAIL illegal_result: got %h want 0", out_result); end
      n_vec++; if (out_zero !== 1'b1) begin n_fail++; $display("FAIL illegal_zero: got %b want 1", out_zero); end
      n_vec++; if (out_tag !== 8'hAA) begin n_fail++; $display("FAIL illegal_tag: got %h want aa", out_tag); end
      @(negedge clk);
      n_vec++; if (out_illegal !== 1'b0) begin n_fail++; $display("FAIL after_illegal_flag: got %b want 0", out_illegal); end
      n_vec++; if (out_result !== 32'd5) begin n_fail++; $display("FAIL after_illegal_result: got %h want 5", out_result); end
      n_vec++; if (out_tag !== 8'h01 || out_zero !== 1'b0) begin
         n_fail++; $display("FAIL after_illegal_tag_zero: got tag=%h z=%b want tag=01 z=0", out_tag, out_zero);
      end
      @(negedge clk);
   endtask

   task automatic test_rst_flight();
      @(negedge clk);
      in_valid = 1'b1; in_op = OpAdd; in_a = 32'd1; in_b = 32'd1; in_tag = 8'h11;
      @(negedge clk);
      in_a = 32'd2; in_tag = 8'h22;
      @(negedge clk);
      // First op sits at the output, second is mid-pipe when reset is applied.
      in_valid = 1'b0; rst = 1'b1;
      #1;
      n_vec++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_flush: got out_valid=%b tag=%h want 0", out_valid, out_tag); end
      rst = 1'b0;
      in_valid = 1'b1; in_op = OpAdd; in_a = 32'd7; in_b = 32'd8; in_tag = 8'h33;
      #1;
      n_vec++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_no_ghost: got out_valid=%b tag=%h want 0", out_valid, out_tag); end
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b1 || out_result !== 32'd15 || out_tag !== 8'h33) begin
         n_fail++; $display("FAIL rst_next_op: got v=%b r=%h tag=%h want v=1 r=0000000f tag=33",
                            out_valid, out_result, out_tag);
      end
   endtask

   task automatic test_mul();
      logic exp_illegal;
`ifdef ALU_MUL_EN
      exp_illegal = 1'b0;
`else
      exp_illegal = 1'b1;
`endif
      @(negedge clk);
      in_valid = 1'b1; in_op = OpMul; in_a = 32'h1_0000; in_b = 32'h1_0000; in_tag = 8'h77;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b1 || out_result !== 32'h0 || out_zero !== 1'b1 || out_tag !== 8'h77) begin
         n_fail++; $display("FAIL mul_result: got v=%b r=%h z=%b tag=%h want v=1 r=0 z=1 tag=77",
                            out_valid, out_result, out_zero, out_tag);
      end
      n_vec++; if (out_illegal !== exp_illegal) begin
         n_fail++; $display("FAIL mul_illegal: got %b want %b", out_illegal, exp_illegal);
      end
   endtask

   initial begin
      n_vec = 0;
      n_fail = 0;
      test_reset();
      test_add_wrap();
      test_ops();
      test_back_to_back();
      test_illegal();
      test_rst_flight();
      test_mul();
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
